// File: rtl/elastic_rr_arbiter.sv
// -----------------------------------------------------------------------------
// elastic_rr_arbiter
//
// Round-robin arbiter that merges N elastic (valid/ready) requester channels
// into one elastic output channel through a single-entry registered stage.
// A synchronous flush empties the output stage and blocks every requester.
// Beats thrown away by a flush are counted in a saturating counter.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_data_i   requester data, requester k at bits [k*DW +: DW]
//   in_valid_i  per-requester valid
//   in_ready_o  per-requester ready (at most one bit set)
//   flush_i     synchronous flush: no accept, held beat discarded if stalled
//   dout_o      output data
//   valid_o     output valid (output stage full)
//   ready_i     downstream ready
//   grant_o     one-hot source of the held beat, 0 when empty
//   drop_cnt_o  saturating count of beats discarded by flush
// -----------------------------------------------------------------------------
module elastic_rr_arbiter #(
    parameter int DW = 16,
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*DW-1:0] in_data_i,
    input  logic [N-1:0]    in_valid_i,
    output logic [N-1:0]    in_ready_o,
    input  logic            flush_i,
    output logic [DW-1:0]   dout_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [N-1:0]    grant_o,
    output logic [CW-1:0]   drop_cnt_o
);

    localparam int            PW    = $clog2(N);
    localparam logic [PW:0]   N_EXT = (PW+1)'(N);
    localparam logic [PW-1:0] LAST  = PW'(N-1);

    logic          full_q;
    logic [DW-1:0] data_q;
    logic [PW-1:0] src_q;
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] drop_q;

    logic [PW-1:0] sel;
    logic          any;
    logic [DW-1:0] sel_data;
    logic          space;
    logic          accept;
    logic          pop;
    logic          discard;

    // Rotating-priority scan: candidates are visited in the order
    // ptr, ptr+1, ..., wrapping modulo N. The extra bit on the candidate
    // index makes the wrap work for N that is not a power of two.
    always_comb begin
        logic [PW:0] cand;
        cand = '0;
        sel  = '0;
        any  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!any && in_valid_i[cand[PW-1:0]]) begin
                any = 1'b1;
                sel = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == PW'(k)) begin
                sel_data = in_data_i[k*DW +: DW];
            end
        end
    end

    // A pop and a push may happen on the same edge, so the stage has room
    // whenever it is empty or is being drained this cycle.
    assign space   = ~full_q | ready_i;
    assign accept  = any & space & ~flush_i;
    assign pop     = full_q & ready_i;
    assign discard = full_q & ~ready_i & flush_i;

    // rst gates ready so no requester sees a handshake while in reset.
    always_comb begin
        in_ready_o = '0;
        for (int k = 0; k < N; k++) begin
            in_ready_o[k] = rst & accept & (sel == PW'(k));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
            ptr_q  <= '0;
        end else begin
            if (accept) begin
                full_q <= 1'b1;
                data_q <= sel_data;
                src_q  <= sel;
                ptr_q  <= (sel == LAST) ? '0 : sel + 1'b1;
            end else if (pop || discard) begin
                full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (discard && (drop_q != {CW{1'b1}})) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign valid_o    = full_q;
    assign dout_o     = data_q;
    assign grant_o    = full_q ? (N'(1) << src_q) : '0;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_elastic_rr_arbiter.sv
module tb_elastic_rr_arbiter;

    localparam int DW = 16;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   dat [N];
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready, in_ready2;
    logic            flush;
    logic            ready;
    logic [DW-1:0]   dout, dout2;
    logic            valid, valid2;
    logic [N-1:0]    grant, grant2;
    logic [7:0]      drop;
    logic [1:0]      drop2;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_full, m_data, m_src, m_ptr, m_drop, m_drop2;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int k = 0; k < N; k++) in_data[k*DW +: DW] = dat[k];
    end

    elastic_rr_arbiter #(.DW(DW), .N(N), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .flush_i(flush), .dout_o(dout), .valid_o(valid),
        .ready_i(ready), .grant_o(grant), .drop_cnt_o(drop));

    elastic_rr_arbiter #(.DW(DW), .N(N), .CW(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready2), .flush_i(flush), .dout_o(dout2), .valid_o(valid2),
        .ready_i(ready), .grant_o(grant2), .drop_cnt_o(drop2));

    typedef struct {
        logic [3:0]  v;
        logic        rdy;
        logic        fl;
        logic [3:0]  e_rdy;
        logic        e_val;
        logic [3:0]  e_gnt;
        logic [15:0] e_dout;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_data = 0; m_src = 0; m_ptr = 0; m_drop = 0; m_drop2 = 0;
    endtask

    // Compare DUT against the model for the current inputs, then advance the
    // model by one clock edge. Called at the falling edge.
    task automatic model_step();
        int  sel;
        bit  found, space, acc;
        found = 0; sel = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && in_valid[(m_ptr + i) % N]) begin
                found = 1;
                sel = (m_ptr + i) % N;
            end
        end
        space = (m_full == 0) || ready;
        acc   = rst && found && space && !flush;
        chk("in_ready", in_ready, acc ? (1 << sel) : 0);
        chk("valid", valid, m_full);
        chk("dout", dout, m_data);
        chk("grant", grant, m_full != 0 ? (1 << m_src) : 0);
        chk("drop_cnt", drop, m_drop);
        chk("drop_cnt_cw2", drop2, m_drop2);
        chk("valid_cw2", valid2, m_full);
        if (!rst) return;
        if (flush && m_full != 0 && !ready) begin
            m_drop  = (m_drop  < 255) ? m_drop  + 1 : 255;
            m_drop2 = (m_drop2 < 3)   ? m_drop2 + 1 : 3;
        end
        if (acc) begin
            m_full = 1;
            m_data = dat[sel];
            m_src  = sel;
            m_ptr  = (sel + 1) % N;
        end else if (m_full != 0 && (ready || flush)) begin
            m_full = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic r, input logic f);
        in_valid = v; ready = r; flush = f;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 16'hA000, 8'd0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010, 16'hA001, 8'd0};
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 16'hA002, 8'd0};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 16'hA003, 8'd0};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 16'hA000, 8'd0};
        tbl[5]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001, 16'hA000, 8'd0};
        tbl[6]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 16'hA002, 8'd0};
        tbl[7]  = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 16'hA003, 8'd0};
        tbl[8]  = '{4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010, 16'hA001, 8'd0};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 16'hA001, 8'd1};
        tbl[10] = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 16'hA002, 8'd1};
        tbl[11] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 16'hA002, 8'd1};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 16'hA002, 8'd1};

        for (int k = 0; k < N; k++) dat[k] = 16'hA000 + 16'(k);
        rst = 1'b0;
        drive(4'b1111, 1'b1, 1'b0);
        model_reset();

        // in reset: no ready even with all requesters valid
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_drop", drop, 0);
        chk("rst_dout", dout, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // table: round robin, stall, wrap, flush cases
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].rdy, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), valid, tbl[i].e_val);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_gnt);
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
            chk($sformatf("tbl%0d_drop", i), drop, tbl[i].e_drop);
        end

        // hold: requester 2 only, downstream stalled
        dat[2] = 16'h1234;
        drive(4'b0100, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", valid, 1);
            chk("hold_dout", dout, 16'h1234);
            chk("hold_grant", grant, 4'b0100);
            model_step();
            @(posedge clk);
            #1;
        end
        drive(4'b0100, 1'b1, 1'b0);
        step();
        step();

        // asynchronous reset while full: outputs clear without a clock edge
        drive(4'b1111, 1'b0, 1'b0);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_grant", grant, 0);
        chk("arst_drop", drop, 0);
        chk("arst_in_ready", in_ready, 0);
        model_reset();
        step();
        rst = 1'b1;
        drive(4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        chk("arst_restart", in_ready, 4'b0001);
        model_step();
        @(posedge clk);
        #1;
        step();

        // CW=2 saturation: five discards
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001, 1'b0, 1'b0);
            step();
            drive(4'b0000, 1'b0, 1'b1);
            step();
            chk("sat_drop_cw2", drop2, (i < 3) ? i + 1 : 3);
            chk("sat_valid", valid, 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) dat[k] = 16'($urandom);
            drive(4'($urandom), ($urandom % 4) != 0, ($urandom % 6) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
